// File: rtl/wasm_frame_ctrl_pkg.sv
// Shared codes for the call-frame controller: commands, completion errors,
// FSM state encodings and the SuperStack op/status codes it drives and observes.
package wasm_frame_ctrl_pkg;

    localparam logic [1:0] FC_CALL      = 2'd0;
    localparam logic [1:0] FC_RETURN    = 2'd1;
    localparam logic [1:0] FC_LOCAL_GET = 2'd2;
    localparam logic [1:0] FC_LOCAL_SET = 2'd3;

    localparam logic [2:0] FC_OK        = 3'd0;
    localparam logic [2:0] FC_ARGS      = 3'd1;
    localparam logic [2:0] FC_FRAME_OVF = 3'd2;
    localparam logic [2:0] FC_FRAME_UDF = 3'd3;
    localparam logic [2:0] FC_NO_RESULT = 3'd4;
    localparam logic [2:0] FC_RANGE     = 3'd5;

    localparam logic [1:0] ST_IDLE        = 2'd0;
    localparam logic [1:0] ST_GET_WAIT    = 2'd1;
    localparam logic [1:0] ST_RET_RESTORE = 2'd2;
    localparam logic [1:0] ST_DONE        = 2'd3;

    localparam logic [2:0] STK_NONE                 = 3'd0;
    localparam logic [2:0] STK_PUSH                 = 3'd1;
    localparam logic [2:0] STK_POP                  = 3'd2;
    localparam logic [2:0] STK_UNDERFLOW_GET        = 3'd3;
    localparam logic [2:0] STK_UNDERFLOW_SET        = 3'd4;
    localparam logic [2:0] STK_UNDERFLOW_RESET      = 3'd5;
    localparam logic [2:0] STK_UNDERFLOW_RESET_PUSH = 3'd6;

    localparam logic [2:0] STS_NONE      = 3'd0;
    localparam logic [2:0] STS_OVERFLOW  = 3'd1;
    localparam logic [2:0] STS_UNDERFLOW = 3'd2;

    // A stack fault reported for an op the controller issued the cycle before.
    function automatic logic stk_fault(input logic [2:0] status);
        return (status == STS_OVERFLOW) || (status == STS_UNDERFLOW);
    endfunction

endpackage

// File: rtl/wasm_frame_ctrl_lifo.sv
// Saved-limit LIFO: entry 0 is always the top, so push/pop are plain shifts
// and no pointer indexing is needed.
module wasm_frame_ctrl_lifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic             full,
    output logic             empty
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [CW-1:0]    count_r;

    assign top   = mem_r[0];
    assign full  = (count_r == CW'(DEPTH));
    assign empty = (count_r == {CW{1'b0}});

    // Shift entries down on push, up on pop; reset clears everything.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_r <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) mem_r[i] <= {WIDTH{1'b0}};
        end else if (push && !full) begin
            count_r  <= count_r + CW'(1);
            mem_r[0] <= din;
            for (int i = 1; i < DEPTH; i++) mem_r[i] <= mem_r[i-1];
        end else if (pop && !empty) begin
            count_r        <= count_r - CW'(1);
            mem_r[DEPTH-1] <= {WIDTH{1'b0}};
            for (int i = 0; i < DEPTH - 1; i++) mem_r[i] <= mem_r[i+1];
        end else begin
            count_r <= count_r;
        end
    end
endmodule

// File: rtl/wasm_frame_ctrl.sv
// Call-frame controller: turns CALL/RETURN/LOCAL_GET/LOCAL_SET into SuperStack
// op sequences and keeps one saved underflow limit per active frame.
module wasm_frame_ctrl
    import wasm_frame_ctrl_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 1,
    parameter int FRAMES = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd,
    input  logic [DEPTH:0]     cmd_arg,
    input  logic [WIDTH-1:0]   cmd_data,
    output logic               done_valid,
    output logic [2:0]         done_err,
    output logic [WIDTH-1:0]   done_data,
    output logic [2:0]         stk_op,
    output logic [WIDTH-1:0]   stk_data,
    output logic [DEPTH:0]     stk_offset,
    output logic [DEPTH:0]     stk_underflow_limit,
    input  logic [DEPTH:0]     stk_index,
    input  logic [WIDTH-1:0]   stk_out,
    input  logic [2:0]         stk_status
);
    localparam int IW = DEPTH + 1;

    logic [1:0]       state_r;
    logic [IW-1:0]    limit_r;
    logic [2:0]       err_r;
    logic [WIDTH-1:0] done_data_r;
    logic             op_issued_r;

    logic             accept_s, nres_s, rej_s, sts_bad_s;
    logic [2:0]       rej_code_s;
    logic [IW-1:0]    avail_s, lifo_top_s;
    logic             lifo_push_s, lifo_pop_s, lifo_full_s, lifo_empty_s;

    assign cmd_ready           = (state_r == ST_IDLE);
    assign accept_s            = cmd_valid && cmd_ready;
    assign nres_s              = (cmd_arg != {IW{1'b0}});
    assign avail_s             = stk_index - limit_r;
    assign sts_bad_s           = op_issued_r && stk_fault(stk_status);
    assign done_valid          = (state_r == ST_DONE);
    assign done_data           = done_data_r;
    assign stk_underflow_limit = limit_r;
    // A fault from an op issued in the accept cycle lands in DONE itself (LOCAL_SET).
    assign done_err = (done_valid && sts_bad_s) ? FC_RANGE : err_r;

    wasm_frame_ctrl_lifo #(.WIDTH(IW), .DEPTH(FRAMES)) u_lifo (
        .clk   (clk),
        .reset (reset),
        .push  (lifo_push_s),
        .pop   (lifo_pop_s),
        .din   (limit_r),
        .top   (lifo_top_s),
        .full  (lifo_full_s),
        .empty (lifo_empty_s)
    );

    // Accept-time checks and the single SuperStack op each command issues.
    always_comb begin
        stk_op      = STK_NONE;
        stk_data    = {WIDTH{1'b0}};
        stk_offset  = {IW{1'b0}};
        rej_s       = 1'b0;
        rej_code_s  = FC_OK;
        lifo_push_s = 1'b0;
        lifo_pop_s  = 1'b0;
        if (accept_s) begin
            case (cmd)
                FC_CALL: begin
                    if (cmd_arg > avail_s) begin
                        rej_s = 1'b1; rej_code_s = FC_ARGS;
                    end else if (lifo_full_s) begin
                        rej_s = 1'b1; rej_code_s = FC_FRAME_OVF;
                    end else begin
                        lifo_push_s = 1'b1;
                    end
                end
                FC_RETURN: begin
                    if (lifo_empty_s) begin
                        rej_s = 1'b1; rej_code_s = FC_FRAME_UDF;
                    end else if (nres_s && (stk_index == limit_r)) begin
                        rej_s = 1'b1; rej_code_s = FC_NO_RESULT;
                    end else begin
                        stk_op   = nres_s ? STK_UNDERFLOW_RESET_PUSH : STK_UNDERFLOW_RESET;
                        stk_data = stk_out;
                    end
                end
                FC_LOCAL_GET: begin
                    if (cmd_arg >= avail_s) begin
                        rej_s = 1'b1; rej_code_s = FC_RANGE;
                    end else begin
                        stk_op = STK_UNDERFLOW_GET; stk_offset = cmd_arg;
                    end
                end
                FC_LOCAL_SET: begin
                    if (cmd_arg >= avail_s) begin
                        rej_s = 1'b1; rej_code_s = FC_RANGE;
                    end else begin
                        stk_op = STK_UNDERFLOW_SET; stk_offset = cmd_arg; stk_data = cmd_data;
                    end
                end
                default: begin
                    rej_s = 1'b0;
                end
            endcase
        end else if (state_r == ST_RET_RESTORE) begin
            lifo_pop_s = 1'b1;
        end else begin
            lifo_pop_s = 1'b0;
        end
    end

    // Sequencer: advances through the per-command states and latches results.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            limit_r     <= {IW{1'b0}};
            err_r       <= FC_OK;
            done_data_r <= {WIDTH{1'b0}};
            op_issued_r <= 1'b0;
        end else begin
            op_issued_r <= (stk_op != STK_NONE);
            case (state_r)
                ST_IDLE: begin
                    if (accept_s && rej_s) begin
                        err_r   <= rej_code_s;
                        state_r <= ST_DONE;
                    end else if (accept_s) begin
                        err_r <= FC_OK;
                        case (cmd)
                            FC_CALL: begin
                                limit_r <= stk_index - cmd_arg;
                                state_r <= ST_DONE;
                            end
                            FC_RETURN: begin
                                done_data_r <= nres_s ? stk_out : {WIDTH{1'b0}};
                                state_r     <= ST_RET_RESTORE;
                            end
                            FC_LOCAL_GET: state_r <= ST_GET_WAIT;
                            FC_LOCAL_SET: begin
                                done_data_r <= cmd_data;
                                state_r     <= ST_DONE;
                            end
                            default: state_r <= ST_IDLE;
                        endcase
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_GET_WAIT: begin
                    done_data_r <= stk_out;
                    err_r       <= sts_bad_s ? FC_RANGE : FC_OK;
                    state_r     <= ST_DONE;
                end
                ST_RET_RESTORE: begin
                    limit_r <= lifo_top_s;
                    err_r   <= sts_bad_s ? FC_RANGE : err_r;
                    state_r <= ST_DONE;
                end
                ST_DONE: state_r <= ST_IDLE;
                default: state_r <= ST_IDLE;
            endcase
        end
    end
endmodule
